// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and MEM-side update bundle for branch_target_buffer.
// The master drives the PCs and the update; the slave (the BTB) returns the prediction.
interface branch_target_buffer_if;
   logic        lookup_pc_dummy_unused;
   logic [31:0] lookup_pc;
   logic        lookup_hit;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic [1:0]  history_out;
   logic        update_en;
   logic [31:0] update_pc;
   logic [31:0] update_target;
   logic [1:0]  update_history;
   logic        invalidate_all;

   modport master (
      output lookup_pc,
      input  lookup_hit,
      input  predict_taken,
      input  predict_target,
      input  history_out,
      output update_en,
      output update_pc,
      output update_target,
      output update_history,
      output invalidate_all
   );

   modport slave (
      input  lookup_pc,
      output lookup_hit,
      output predict_taken,
      output predict_target,
      output history_out,
      input  update_en,
      input  update_pc,
      input  update_target,
      input  update_history,
      input  invalidate_all
   );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup by PC, write-back of target/history from MEM.
// Define BTB_FWD_EN to forward a same-index update straight to the lookup port.
module branch_target_buffer #(
   parameter int ENTRIES = 16
) (
   input logic                  CLK,
   input logic                  nRST,
   branch_target_buffer_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [TAG_W-1:0] tag_t;

   logic [ENTRIES-1:0] valid;
   tag_t               tags    [ENTRIES];
   logic [31:0]        targets [ENTRIES];
   logic [1:0]         hists   [ENTRIES];

   idx_t l_idx;
   idx_t u_idx;
   tag_t l_tag;
   tag_t u_tag;

   assign l_idx = bus.lookup_pc[IDX_W+1:2];
   assign l_tag = bus.lookup_pc[31:IDX_W+2];
   assign u_idx = bus.update_pc[IDX_W+1:2];
   assign u_tag = bus.update_pc[31:IDX_W+2];

   // Invalidate outranks a concurrent update: the update is dropped.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tags[i]    <= '0;
            targets[i] <= '0;
            hists[i]   <= '0;
         end
      end else if (bus.invalidate_all) begin
         valid <= '0;
      end else if (bus.update_en) begin
         valid[u_idx]   <= 1'b1;
         tags[u_idx]    <= u_tag;
         targets[u_idx] <= bus.update_target;
         hists[u_idx]   <= bus.update_history;
      end
   end

   logic        e_valid;
   tag_t        e_tag;
   logic [31:0] e_target;
   logic [1:0]  e_hist;
   logic        hit;

   always_comb begin
      e_valid  = valid[l_idx];
      e_tag    = tags[l_idx];
      e_target = targets[l_idx];
      e_hist   = hists[l_idx];
`ifdef BTB_FWD_EN
      if (bus.update_en && !bus.invalidate_all
          && (u_idx == l_idx)) begin
         e_valid  = 1'b1;
         e_tag    = u_tag;
         e_target = bus.update_target;
         e_hist   = bus.update_history;
      end
`endif
   end

   assign hit                = e_valid && (e_tag == l_tag);
   assign bus.lookup_hit     = hit;
   assign bus.predict_taken  = hit & e_hist[1];
   assign bus.predict_target = hit ? e_target
                                   : bus.lookup_pc + 32'd4;
   assign bus.history_out    = hit ? e_hist : 2'b00;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus queues expected lookups,
// a negedge monitor pops and compares them.
module tb_branch_target_buffer;
   logic CLK;
   logic nRST;

   branch_target_buffer_if bus ();

   branch_target_buffer #(.ENTRIES(16)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   typedef struct {
      string       name;
      logic        hit;
      logic        taken;
      logic [31:0] target;
      logic [1:0]  hist;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_fails  = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.name, ".hit"}, {31'd0, bus.lookup_hit}, {31'd0, e.hit});
         check({e.name, ".taken"}, {31'd0, bus.predict_taken},
               {31'd0, e.taken});
         check({e.name, ".target"}, bus.predict_target, e.target);
         check({e.name, ".hist"}, {30'd0, bus.history_out}, {30'd0, e.hist});
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_lk(input string name, input logic [31:0] pc,
                            input logic h, input logic t,
                            input logic [31:0] tgt, input logic [1:0] hs);
      exp_t e;
      bus.lookup_pc = pc;
      e.name = name;
      e.hit = h;
      e.taken = t;
      e.target = tgt;
      e.hist = hs;
      sb.push_back(e);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                      input logic [1:0] hs);
      bus.update_en      = 1'b1;
      bus.update_pc      = pc;
      bus.update_target  = tgt;
      bus.update_history = hs;
   endtask

   initial begin
      nRST               = 1'b0;
      bus.lookup_pc      = 32'h0;
      bus.update_en      = 1'b0;
      bus.update_pc      = 32'h0;
      bus.update_target  = 32'h0;
      bus.update_history = 2'b00;
      bus.invalidate_all = 1'b0;

      #2;
      expect_lk("reset", 32'h100, 0, 0, 32'h104, 2'b00);
      #10;
      nRST = 1'b1;
      step();

      // basic write then read
      upd(32'h100, 32'h40, 2'b11);
      bus.lookup_pc = 32'h100;
      step();
      bus.update_en = 1'b0;
      expect_lk("hit_hard_taken", 32'h100, 1, 1, 32'h40, 2'b11);
      step();

      // same-index alias, last writer wins
      upd(32'h100, 32'h50, 2'b10);
      step();
      upd(32'h140, 32'h60, 2'b01);
      step();
      bus.update_en = 1'b0;
      expect_lk("alias_evicted", 32'h100, 0, 0, 32'h104, 2'b00);
      step();
      expect_lk("alias_winner", 32'h140, 1, 0, 32'h60, 2'b01);
      step();

      upd(32'h104, 32'h80, 2'b10);
      step();
      upd(32'h108, 32'h88, 2'b00);
      step();
      bus.update_en = 1'b0;
      expect_lk("soft_taken", 32'h104, 1, 1, 32'h80, 2'b10);
      step();
      expect_lk("hard_not_taken", 32'h108, 1, 0, 32'h88, 2'b00);
      step();
      expect_lk("pc_low_bits_ignored", 32'h10B, 1, 0, 32'h88, 2'b00);
      step();

      // fill every entry
      for (int i = 0; i < 16; i++) begin
         upd(32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 2'(i));
         step();
      end
      bus.update_en = 1'b0;
      expect_lk("fill_e3", 32'h40C, 1, 1, 32'h1003, 2'b11);
      step();
      expect_lk("fill_e14", 32'h438, 1, 1, 32'h100E, 2'b10);
      step();

      // invalidate wins over concurrent update
      upd(32'h200, 32'h222, 2'b11);
      bus.invalidate_all = 1'b1;
      bus.lookup_pc = 32'h400;
      step();
      bus.update_en      = 1'b0;
      bus.invalidate_all = 1'b0;
      expect_lk("inval_e0", 32'h400, 0, 0, 32'h404, 2'b00);
      step();
      expect_lk("inval_e15", 32'h43C, 0, 0, 32'h440, 2'b00);
      step();
      expect_lk("inval_dropped_upd", 32'h200, 0, 0, 32'h204, 2'b00);
      step();

      // update_en low must not write
      bus.update_en     = 1'b0;
      bus.update_pc     = 32'h504;
      bus.update_target = 32'h999;
      step();
      expect_lk("no_write_when_idle", 32'h504, 0, 0, 32'h508, 2'b00);
      step();

      // same-cycle update and lookup
      upd(32'h300, 32'h700, 2'b11);
`ifdef BTB_FWD_EN
      expect_lk("same_cycle", 32'h300, 1, 1, 32'h700, 2'b11);
`else
      expect_lk("same_cycle", 32'h300, 0, 0, 32'h304, 2'b00);
`endif
      step();
      bus.update_en = 1'b0;
      expect_lk("next_cycle", 32'h300, 1, 1, 32'h700, 2'b11);
      step();

      expect_lk("wrap_target", 32'hFFFF_FFFC, 0, 0, 32'h0, 2'b00);
      step();

      // reset asserted mid-update
      upd(32'h604, 32'h900, 2'b11);
      bus.lookup_pc = 32'h300;
      #2;
      nRST = 1'b0;
      #1;
      expect_lk("async_clear", 32'h300, 0, 0, 32'h304, 2'b00);
      step();
      nRST = 1'b1;
      bus.update_en = 1'b0;
      expect_lk("reset_drops_write", 32'h604, 0, 0, 32'h608, 2'b00);
      step();
      expect_lk("reset_cleared", 32'h140, 0, 0, 32'h144, 2'b00);
      step();

      for (int i = 0; i < 10 && sb.size() > 0; i++) step();
      if (sb.size() != 0) begin
         n_fails++;
         $display("FAIL drain: %0d pending, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end
endmodule
